sram_bayesian_bank: RTL and testbench
=====================================

// Module: sram_bayesian_bank
// PURPOSE
//  Parametrised read/write word store for the Bayesian compute core: a generalised
//  successor of the fixed 4x8 read-only table. Self-initialises to the prior pattern
//  after reset or on request, then serves single-port read/write requests through
//  valid/ready handshakes, with a backpressured, registered read response.
// PARAMETERS
//  WORD_SIZE  8                    data width in bits (>=8)
//  NUM_WORDS  16                   depth; need not be a power of two (>=2)
//  ADDR_W     $clog2(NUM_WORDS)    address width (derived; do not override)
//  INIT_MODE  1                    0: fill with zeros; 1: fill with prior pattern
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  init_req   in   1          one-cycle pulse: restart initialisation
//  init_done  out  1          1 = array initialised, requests may be accepted
//  req_valid  in   1          request present
//  req_ready  out  1          request accepted when req_valid && req_ready
//  req_we     in   1          1 = write, 0 = read
//  req_addr   in   ADDR_W     word address
//  req_wdata  in   WORD_SIZE  write data
//  rsp_valid  out  1          read response present
//  rsp_ready  in   1          response consumed when rsp_valid && rsp_ready
//  rsp_data   out  WORD_SIZE  read data
//  rsp_err    out  1          response is for an out-of-range address
// BEHAVIOUR
//  - Reset: state=INIT, init_cnt=0, init_done=0, req_ready=0, rsp_valid=0,
//    rsp_data=0, rsp_err=0. Any pending response is discarded.
//  - Prior pattern: word i = byte P[i mod 4], P = {8'hA5, 8'hCC, 8'h5A, 8'hF0},
//    replicated across WORD_SIZE, truncated at the MSB end.
//  - FSM INIT: writes word init_cnt each cycle (pattern or zero per INIT_MODE);
//    after word NUM_WORDS-1 is written -> READY; init_done=1 from the next cycle.
//    Initialisation takes exactly NUM_WORDS cycles.
//  - FSM READY: req_ready = !init_req && (!rsp_valid || rsp_ready), combinational.
//  - Read accepted at cycle T: rsp_valid=1 at T+1 with rsp_data=mem[addr].
//    Latency 1. Back-to-back reads sustain 1 per cycle while rsp_ready=1.
//  - Write accepted at T: mem[addr] updated at the T edge; no response produced.
//    Read of the same address accepted at T+1 returns the new data.
//  - Backpressure: while rsp_valid && !rsp_ready, rsp_data/rsp_err hold stable,
//    req_ready=0. rsp_valid drops the cycle after consumption unless a new read
//    is accepted in the same cycle (response slot reuse).
//  - Out-of-range (addr >= NUM_WORDS): read returns rsp_data=0, rsp_err=1;
//    write is dropped with no side effect.
//  - init_req in READY: wins over a same-cycle request (not accepted); next cycle
//    state=INIT, init_done=0, init_cnt=0. A pending response is still delivered
//    (held until rsp_ready). init_req during INIT is ignored.
//  - rst mid-operation: same as power-up reset; array re-initialised.
// STRUCTURE
//  - Package sram_bayesian_pkg: state enum {ST_INIT, ST_READY}; prior
//    pattern constant array P; function building the replicated init word.
//  - Sub-module sram_bayesian_array: NUM_WORDS x WORD_SIZE storage, one write
//    port, one synchronous read port; no reset on storage.
//  - Top holds FSM, init counter, handshake logic, response register.
// TESTING
//  1 Reset then idle, defaults: init_done rises after exactly 16 cycles; reads
//    of addr 0..5 return A5,CC,5A,F0,A5,CC with rsp_err=0.
//  2 Write addr 3 = 8'h3C, read addr 3 next cycle -> rsp_data=8'h3C one cycle later.
//  3 Read addr 7 with rsp_ready=0 for 3 cycles -> rsp_data=8'hF0 held stable,
//    req_ready=0 throughout; releases on rsp_ready=1.
//  4 NUM_WORDS=10: read addr 12 -> rsp_err=1, rsp_data=0; write addr 12 then
//    full sweep shows array unchanged.
//  5 After writing addr 0 = 8'h00, pulse init_req alongside a read request ->
//    request not accepted, init_done=0 for 16 cycles, then addr 0 reads 8'hA5.
//  6 Assert rst during back-to-back reads -> rsp_valid=0 next cycle, re-init runs.

Source files
------------

// File: rtl/sram_bayesian_pkg.sv
// Shared types and the prior-pattern generator for the Bayesian word store.
package sram_bayesian_pkg;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // Widest word the pattern generator can build; callers keep the low bits.
    localparam int MAX_WORD = 256;

    localparam logic [7:0] PRIOR [4] = '{8'hA5, 8'hCC, 8'h5A, 8'hF0};

    function automatic logic [MAX_WORD-1:0] prior_word(input int idx);
        logic [MAX_WORD-1:0] w;
        logic [1:0]          sel;
        sel = 2'(idx);
        for (int j = 0; j < MAX_WORD / 8; j++) begin
            w[j*8 +: 8] = PRIOR[sel];
        end
        return w;
    endfunction

endpackage

// File: rtl/sram_bayesian_bank_if.sv
// Request/response handshake bundle between a requester and the word store.
interface sram_bayesian_bank_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_W    = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sram_bayesian_array.sv
// NUM_WORDS x WORD_SIZE storage with one write port and one registered read port.
module sram_bayesian_array #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [NUM_WORDS];

    // NOTE: storage carries no reset so it maps onto plain RAM; contents are
    // established by the owner's initialisation sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sram_bayesian_bank.sv
// Self-initialising read/write word store with valid/ready request and response.
module sram_bayesian_bank
    import sram_bayesian_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = $clog2(NUM_WORDS),
    parameter int INIT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_req,
    output logic                 init_done,
    sram_bayesian_bank_if.slave  bus
);

    state_t               state;
    logic [ADDR_W-1:0]    init_cnt;
    logic                 in_range;
    logic                 accept;
    logic                 rd_accept;
    logic                 data_ok;
    logic                 arr_we;
    logic                 arr_re;
    logic [ADDR_W-1:0]    arr_waddr;
    logic [WORD_SIZE-1:0] arr_wdata;
    logic [WORD_SIZE-1:0] arr_rdata;
    logic [WORD_SIZE-1:0] init_word;
    logic [MAX_WORD-1:0]  prior_full;

    assign in_range      = int'(bus.req_addr) < NUM_WORDS;
    assign bus.req_ready = (state == ST_READY) && !init_req
                           && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_accept     = accept && !bus.req_we;
    assign arr_re        = rd_accept && in_range;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    always_comb begin
        prior_full = prior_word(int'(init_cnt));
        init_word  = (INIT_MODE != 0) ? prior_full[WORD_SIZE-1:0] : '0;
        arr_we     = 1'b0;
        arr_waddr  = bus.req_addr;
        arr_wdata  = bus.req_wdata;
        if (state == ST_INIT) begin
            arr_we    = 1'b1;
            arr_waddr = init_cnt;
            arr_wdata = init_word;
        end else begin
            arr_we = accept && bus.req_we && in_range;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == ADDR_W'(NUM_WORDS - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                        init_cnt  <= '0;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (init_req) begin
                        state     <= ST_INIT;
                        init_done <= 1'b0;
                        init_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    init_done <= 1'b0;
                    init_cnt  <= '0;
                end
            endcase
        end
    end

    // Response slot: a new read may refill it in the same cycle it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            data_ok       <= 1'b0;
        end else if (rd_accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !in_range;
            data_ok       <= in_range;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    // Out-of-range reads and the post-reset slot present zero data.
    assign bus.rsp_data = data_ok ? arr_rdata : '0;

    sram_bayesian_array #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (bus.req_addr),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_sram_bayesian_bank.sv
// Directed bench for sram_bayesian_bank: a 16-word default instance and a 10-word instance.
module tb_sram_bayesian_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_req_a = 1'b0;
    logic init_req_b = 1'b0;
    logic init_done_a;
    logic init_done_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] prior [4] = '{8'hA5, 8'hCC, 8'h5A, 8'hF0};

    sram_bayesian_bank_if #(.WORD_SIZE(8), .ADDR_W(4)) bus_a ();
    sram_bayesian_bank_if #(.WORD_SIZE(8), .ADDR_W(4)) bus_b ();

    sram_bayesian_bank #(.WORD_SIZE(8), .NUM_WORDS(16), .INIT_MODE(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req_a),
        .init_done (init_done_a),
        .bus       (bus_a.slave)
    );

    sram_bayesian_bank #(.WORD_SIZE(8), .NUM_WORDS(10), .INIT_MODE(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req_b),
        .init_done (init_done_b),
        .bus       (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0;   bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0;   bus_b.rsp_ready = 1'b1;

        // 1: reset defaults, init length, prior pattern
        step(); step();
        check("rst_init_done", init_done_a, 0);
        check("rst_req_ready", bus_a.req_ready, 0);
        check("rst_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_rsp_data", bus_a.rsp_data, 0);
        check("rst_rsp_err", bus_a.rsp_err, 0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("init_done_c15", init_done_a, 0);
            if (i == 16) check("init_done_c16", init_done_a, 1);
        end
        check("init_done_b", init_done_b, 1);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_a.req_addr = 4'(k);
            step();
            check("prior_valid", bus_a.rsp_valid, 1);
            check("prior_data", bus_a.rsp_data, {24'h0, prior[k % 4]});
            check("prior_err", bus_a.rsp_err, 0);
        end
        bus_a.req_valid = 1'b0;
        step();
        check("prior_drain", bus_a.rsp_valid, 0);

        // 2: write then read same address
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 4'd3; bus_a.req_wdata = 8'h3C;
        step();
        check("wr_no_rsp", bus_a.rsp_valid, 0);
        bus_a.req_we = 1'b0;
        step();
        check("raw_valid", bus_a.rsp_valid, 1);
        check("raw_data", bus_a.rsp_data, 8'h3C);
        bus_a.req_valid = 1'b0;
        step();
        check("raw_drain", bus_a.rsp_valid, 0);

        // 3: backpressure holds response and blocks requests
        bus_a.rsp_ready = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 4'd7;
        step();
        check("bp_data_first", bus_a.rsp_data, 8'hF0);
        bus_a.req_addr = 4'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_req_ready", bus_a.req_ready, 0);
            check("bp_valid_hold", bus_a.rsp_valid, 1);
            check("bp_data_hold", bus_a.rsp_data, 8'hF0);
            step();
        end
        bus_a.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", bus_a.req_ready, 1);
        step();
        check("bp_reuse_valid", bus_a.rsp_valid, 1);
        check("bp_reuse_data", bus_a.rsp_data, 8'hCC);
        bus_a.req_valid = 1'b0;
        step();
        check("bp_drain", bus_a.rsp_valid, 0);

        // 4: out-of-range on the 10-word instance
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 4'd2;
        step();
        check("oor_pre_data", bus_b.rsp_data, 8'h5A);
        bus_b.req_addr = 4'd12;
        step();
        check("oor_valid", bus_b.rsp_valid, 1);
        check("oor_err", bus_b.rsp_err, 1);
        check("oor_data", bus_b.rsp_data, 0);
        bus_b.req_we = 1'b1; bus_b.req_wdata = 8'h77;
        step();
        check("oor_wr_no_rsp", bus_b.rsp_valid, 0);
        bus_b.req_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus_b.req_addr = 4'(k);
            step();
            check("sweep_data", bus_b.rsp_data, {24'h0, prior[k % 4]});
            check("sweep_err", bus_b.rsp_err, 0);
        end
        bus_b.req_valid = 1'b0;
        step();

        // 5: init_req beats a same-cycle request and restores the prior pattern
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 4'd0; bus_a.req_wdata = 8'h00;
        step();
        bus_a.req_we = 1'b0;
        step();
        check("zero_word", bus_a.rsp_data, 8'h00);
        init_req_a = 1'b1; bus_a.req_addr = 4'd1;
        #1;
        check("ireq_block", bus_a.req_ready, 0);
        step();
        init_req_a = 1'b0; bus_a.req_valid = 1'b0;
        check("ireq_done_low", init_done_a, 0);
        check("ireq_not_acc", bus_a.rsp_valid, 0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("reinit_c15", init_done_a, 0);
            if (i == 16) check("reinit_c16", init_done_a, 1);
        end
        bus_a.req_valid = 1'b1; bus_a.req_addr = 4'd0;
        step();
        check("reinit_addr0", bus_a.rsp_data, 8'hA5);
        bus_a.req_addr = 4'd3;
        step();
        check("reinit_addr3", bus_a.rsp_data, 8'hF0);
        bus_a.req_valid = 1'b0;
        step();

        // 6: reset during back-to-back reads
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 4'd6; bus_a.req_wdata = 8'h11;
        step();
        bus_a.req_we = 1'b0; bus_a.req_addr = 4'd4;
        step();
        check("b2b_a4", bus_a.rsp_data, 8'hA5);
        bus_a.req_addr = 4'd5;
        step();
        check("b2b_a5", bus_a.rsp_data, 8'hCC);
        rst = 1'b1;
        step();
        check("mid_rst_valid", bus_a.rsp_valid, 0);
        check("mid_rst_done", init_done_a, 0);
        check("mid_rst_ready", bus_a.req_ready, 0);
        rst = 1'b0; bus_a.req_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("rst_reinit_c15", init_done_a, 0);
            if (i == 16) check("rst_reinit_c16", init_done_a, 1);
        end
        bus_a.req_valid = 1'b1; bus_a.req_addr = 4'd6;
        step();
        check("rst_reinit_a6", bus_a.rsp_data, 8'h5A);
        bus_a.req_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
